// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants and state type for the round-robin grant arbiter.
// Purely declarative; no latency and no backpressure.
package arb_pkg;
    localparam int ARB_N   = 8;
    localparam int ARB_IDW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Wires only; no latency; the grant itself is the backpressure toward requesters.
interface rr_grant_arbiter_if;
    import arb_pkg::*;

    logic [ARB_N-1:0]   req;
    logic               done;
    logic [ARB_N-1:0]   gnt;
    logic [ARB_IDW-1:0] gnt_id;
    logic               gnt_valid;
    logic               timeout;

    modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping 7 to 0.
// Zero latency; no backpressure.
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]   req,
    input  logic [ARB_IDW-1:0] ptr,
    output logic [ARB_N-1:0]   win,
    output logic [ARB_IDW-1:0] win_id,
    output logic               found
);
    logic [ARB_N-1:0]   rot;
    logic [ARB_IDW-1:0] rot_id;

    // rot[0] is the requester sitting at ptr, so the lowest set bit wins.
    always_comb begin
        rot = '0;
        for (int i = 0; i < ARB_N; i++) begin
            rot[i] = req[ptr + ARB_IDW'(i)];
        end
    end

    always_comb begin
        rot_id = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) rot_id = ARB_IDW'(i);
        end
    end

    assign found  = |req;
    assign win_id = rot_id + ptr;
    assign win    = found ? (ARB_N'(1) << win_id) : '0;
endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter, 8 requesters, grant held until done / req drop / hold limit.
// Grant 1 cycle after req in IDLE, handover 1 cycle after release with no bubble; no backpressure.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_HIT = CW'(MAX_HOLD - 1);

    arb_state_t         state, state_nxt;
    logic [ARB_IDW-1:0] ptr, ptr_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [ARB_N-1:0]   gnt_q, gnt_nxt;
    logic [ARB_IDW-1:0] id_q, id_nxt;
    logic               vld_q, vld_nxt;
    logic               to_q, to_nxt;

    logic               own, hold_hit, rel_done, rel_drop, rel_to, rel;
    logic [ARB_IDW-1:0] pick_ptr, pick_id;
    logic [ARB_N-1:0]   pick_req, pick_gnt;
    logic               pick_found;

    assign own      = (state == OWN);
    assign hold_hit = (MAX_HOLD != 0) && (cnt == CNT_HIT);
    assign rel_done = own & bus.done;
    assign rel_drop = own & ~bus.req[id_q];
    assign rel_to   = own & hold_hit & ~bus.done;
    assign rel      = rel_done | rel_drop | rel_to;

    // On release the owner ranks last; a done-release drops it from this pick entirely.
    assign pick_ptr = rel ? (id_q + ARB_IDW'(1)) : ptr;
    assign pick_req = rel_done ? (bus.req & ~gnt_q) : bus.req;

    rr_pick u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .win    (pick_gnt),
        .win_id (pick_id),
        .found  (pick_found)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        vld_nxt   = vld_q;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    gnt_nxt   = pick_gnt;
                    id_nxt    = pick_id;
                    vld_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            OWN: begin
                if (rel) begin
                    ptr_nxt = pick_ptr;
                    to_nxt  = rel_to;
                    cnt_nxt = '0;
                    if (pick_found) begin
                        gnt_nxt = pick_gnt;
                        id_nxt  = pick_id;
                        vld_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        id_nxt    = '0;
                        vld_nxt   = 1'b0;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt_q <= '0;
            id_q  <= '0;
            vld_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt_q <= gnt_nxt;
            id_q  <= id_nxt;
            vld_q <= vld_nxt;
            to_q  <= to_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed vector table, hand sequences and a random run
// checked against an owner/held-cycles reference model.
module tb_rr_grant_arbiter;
    import arb_pkg::*;

    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_grant_arbiter_if ifc ();

    rr_grant_arbiter #(.MAX_HOLD(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns, how many cycles it has been shown, where the search starts.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int search(input int start, input logic [7:0] elig);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        bit         rd, rp, rt;
        logic [7:0] e;
        if (m_owner < 0) begin
            m_owner = search(m_ptr, r);
            m_held  = (m_owner >= 0) ? 1 : 0;
            m_to    = 1'b0;
        end else begin
            rd = d;
            rp = !r[m_owner];
            rt = (M != 0) && (m_held == M) && !d;
            if (rd || rp || rt) begin
                e = r;
                if (rd) e[m_owner] = 1'b0;
                m_ptr   = (m_owner + 1) % 8;
                m_to    = rt;
                m_owner = search(m_ptr, e);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic model_cmp();
        logic [7:0] one;
        logic [7:0] eg;
        one = 8'h01;
        eg  = (m_owner >= 0) ? (one << m_owner) : 8'h00;
        chk("model_gnt",    {24'h0, ifc.gnt},    {24'h0, eg});
        chk("model_gnt_id", {29'h0, ifc.gnt_id}, (m_owner >= 0) ? m_owner : 0);
        chk("model_valid",  {31'h0, ifc.gnt_valid}, {31'h0, (m_owner >= 0)});
        chk("model_timeout", {31'h0, ifc.timeout}, {31'h0, m_to});
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        ifc.req  = r;
        ifc.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        model_cmp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifc.req  = 8'h00;
        ifc.done = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("reset_gnt",     {24'h0, ifc.gnt},       32'h0);
        chk("reset_gnt_id",  {29'h0, ifc.gnt_id},    32'h0);
        chk("reset_valid",   {31'h0, ifc.gnt_valid}, 32'h0);
        chk("reset_timeout", {31'h0, ifc.timeout},   32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                                input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.gnt = g; x.id = i; x.vld = v; x.to = t;
        return x;
    endfunction

    initial begin
        ifc.req  = 8'h00;
        ifc.done = 1'b0;

        // idle, single requester with done, pointer effect, wrap from 7, hold limit, drops
        for (int i = 0; i < 5; i++) vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(8'h01, 0, 8'h01, 0, 1, 0));
        vecs.push_back(mk(8'h01, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(8'h03, 0, 8'h02, 1, 1, 0));
        vecs.push_back(mk(8'h03, 1, 8'h01, 0, 1, 0));
        vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(8'h40, 0, 8'h40, 6, 1, 0));
        vecs.push_back(mk(8'h40, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(8'h81, 0, 8'h80, 7, 1, 0));
        vecs.push_back(mk(8'h81, 1, 8'h01, 0, 1, 0));
        vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(8'h24, 0, 8'h04, 2, 1, 0));
        vecs.push_back(mk(8'h24, 0, 8'h20, 5, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(8'h24, 0, 8'h20, 5, 1, 0));
        vecs.push_back(mk(8'h24, 0, 8'h04, 2, 1, 1));
        vecs.push_back(mk(8'h08, 0, 8'h08, 3, 1, 0));
        vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(8'h10, 0, 8'h10, 4, 1, 0));
        vecs.push_back(mk(8'h10, 1, 8'h00, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(8'h20, 0, 8'h20, 5, 1, 0));
        vecs.push_back(mk(8'h20, 0, 8'h20, 5, 1, 1));
        vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0));

        do_reset();
        foreach (vecs[n]) begin
            step(vecs[n].req, vecs[n].done);
            chk($sformatf("vec%0d_gnt", n),     {24'h0, ifc.gnt},       {24'h0, vecs[n].gnt});
            chk($sformatf("vec%0d_gnt_id", n),  {29'h0, ifc.gnt_id},    {29'h0, vecs[n].id});
            chk($sformatf("vec%0d_valid", n),   {31'h0, ifc.gnt_valid}, {31'h0, vecs[n].vld});
            chk($sformatf("vec%0d_timeout", n), {31'h0, ifc.timeout},   {31'h0, vecs[n].to});
        end

        // All requesting, done every third cycle: owners rotate 0..7,0 with no idle gap.
        do_reset();
        step(8'hFF, 1'b0);
        chk("ff_first_id", {29'h0, ifc.gnt_id}, 32'd0);
        for (int n = 0; n < 27; n++) begin
            step(8'hFF, (n % 3) == 2);
            chk($sformatf("ff%0d_id", n), {29'h0, ifc.gnt_id}, ((n + 1) / 3) % 8);
            chk($sformatf("ff%0d_valid", n), {31'h0, ifc.gnt_valid}, 32'd1);
        end

        // Reset asserted mid-grant clears outputs without a clock edge.
        chk("pre_reset_valid", {31'h0, ifc.gnt_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_gnt",   {24'h0, ifc.gnt},       32'h0);
        chk("async_reset_valid", {31'h0, ifc.gnt_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            logic       d;
            case ($urandom_range(0, 3))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = 8'($urandom) & 8'($urandom) & 8'($urandom);
                default: r = (m_owner >= 0 && $urandom_range(0, 1) == 1) ? (8'h01 << m_owner) | 8'($urandom_range(0, 1)) : 8'h00;
            endcase
            d = ($urandom_range(0, 5) == 0);
            step(r, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
